jace_tape_player: RTL

Tape-signal generator that produces the EAR waveform the Jupiter Ace logic samples on port 0xFE bit 5. It is the transmitting end of the cassette interface. It takes a byte stream from the tape-image loader through a valid/ready handshake. It emits one Ace-format block: pilot tone, two sync halves, MSB-first data bits and a tail pulse. It sits between the image loader and the `ear` input of the machine logic, clocked by the 6.5 MHz pixel clock.

---
 rtl/jace_tape_pkg.sv | 44 ++++
 rtl/jace_tape_player_if.sv | 21 ++
 rtl/jace_tape_halfgen.sv | 41 ++++
 rtl/jace_tape_player.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jace_tape_pkg.sv
// Shared definitions for the Jupiter Ace cassette signal path: player FSM
// states, default half-period lengths (in 6.5 MHz clk cycles, 2 per T-state)
// and the pilot pulse counts for header and data blocks.
package jace_tape_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PILOT = 3'd1,
        ST_SYNC1 = 3'd2,
        ST_SYNC2 = 3'd3,
        ST_DATA  = 3'd4,
        ST_STALL = 3'd5,
        ST_TAIL  = 3'd6
    } tape_state_e;

    localparam int unsigned HALF_W  = 32'd12;
    localparam int unsigned PULSE_W = 32'd14;

    localparam int unsigned DEF_PILOT_HALF  = 32'd4022;
    localparam int unsigned DEF_SYNC1_HALF  = 32'd1202;
    localparam int unsigned DEF_SYNC2_HALF  = 32'd1582;
    localparam int unsigned DEF_ZERO_HALF   = 32'd1590;
    localparam int unsigned DEF_ONE_HALF    = 32'd3170;
    localparam int unsigned DEF_TAIL_HALF   = 32'd1894;

    localparam int unsigned DEF_HDR_PULSES  = 32'd8192;
    localparam int unsigned DEF_DATA_PULSES = 32'd1024;

    // Half-period length that encodes one data bit.
    function automatic logic [HALF_W-1:0] bit_half_len(
        input logic              bit_val,
        input logic [HALF_W-1:0] one_len,
        input logic [HALF_W-1:0] zero_len
    );
        logic [HALF_W-1:0] len_s;
        if (bit_val) begin
            len_s = one_len;
        end else begin
            len_s = zero_len;
        end
        return len_s;
    endfunction

endpackage

// File: rtl/jace_tape_player_if.sv
// Byte stream from the tape-image loader into the tape player.
interface jace_tape_player_if;
    logic [7:0] data_in;
    logic       data_last;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output data_in,
        output data_last,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_last,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/jace_tape_halfgen.sv
// Half-period generator: a loadable down-counter with a level register.
// A load sets both the length and the level of the next half; half_done_o
// strobes during the last cycle of a running half so the owner can load
// the following one on the same edge.
module jace_tape_halfgen
    import jace_tape_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [HALF_W-1:0] len_i,
    input  logic              level_i,
    input  logic              en_i,
    output logic              level_o,
    output logic              half_done_o
);

    logic [HALF_W-1:0] count_q;
    logic              level_q;

    // Count register and output level; load has priority over counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            level_q <= 1'b0;
        end else if (load_i) begin
            count_q <= len_i;
            level_q <= level_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - HALF_W'(1);
            level_q <= level_q;
        end else begin
            count_q <= count_q;
            level_q <= level_q;
        end
    end

    assign level_o     = level_q;
    assign half_done_o = en_i && (count_q == HALF_W'(1));

endmodule

// File: rtl/jace_tape_player.sv
// Jupiter Ace tape signal generator: plays one block (pilot, sync, MSB-first
// data bits, tail) on the EAR level from a valid/ready byte stream.
module jace_tape_player
    import jace_tape_pkg::*;
#(
    parameter int unsigned PILOT_HALF  = DEF_PILOT_HALF,
    parameter int unsigned HDR_PULSES  = DEF_HDR_PULSES,
    parameter int unsigned DATA_PULSES = DEF_DATA_PULSES,
    parameter int unsigned SYNC1_HALF  = DEF_SYNC1_HALF,
    parameter int unsigned SYNC2_HALF  = DEF_SYNC2_HALF,
    parameter int unsigned ZERO_HALF   = DEF_ZERO_HALF,
    parameter int unsigned ONE_HALF    = DEF_ONE_HALF,
    parameter int unsigned TAIL_HALF   = DEF_TAIL_HALF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_header,
    input  logic               abort,
    jace_tape_player_if.slave  src,
    output logic               ear,
    output logic               busy,
    output logic               done,
    output logic               underrun
);

    localparam logic [HALF_W-1:0]  L_PILOT = HALF_W'(PILOT_HALF);
    localparam logic [HALF_W-1:0]  L_SYNC1 = HALF_W'(SYNC1_HALF);
    localparam logic [HALF_W-1:0]  L_SYNC2 = HALF_W'(SYNC2_HALF);
    localparam logic [HALF_W-1:0]  L_ZERO  = HALF_W'(ZERO_HALF);
    localparam logic [HALF_W-1:0]  L_ONE   = HALF_W'(ONE_HALF);
    localparam logic [HALF_W-1:0]  L_TAIL  = HALF_W'(TAIL_HALF);
    localparam logic [PULSE_W-1:0] L_HDR   = PULSE_W'(HDR_PULSES);
    localparam logic [PULSE_W-1:0] L_DAT   = PULSE_W'(DATA_PULSES);

    tape_state_e        state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               underrun_q, underrun_d;
    logic [PULSE_W-1:0] pulse_q, pulse_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               shift_last_q, shift_last_d;
    logic [7:0]         hold_q, hold_d;
    logic               hold_last_q, hold_last_d;
    logic               hold_full_q, hold_full_d;
    logic               last_seen_q, last_seen_d;

    logic               hg_load_s;
    logic [HALF_W-1:0]  hg_len_s;
    logic               hg_level_s;
    logic               hg_en_s;
    logic               hg_level_o_s;
    logic               hg_done_s;

    logic               ready_s;
    logic               xfer_s;
    logic               avail_s;
    logic [7:0]         next_byte_s;
    logic               next_last_s;
    logic               load_pt_s;

    jace_tape_halfgen u_halfgen (
        .clk         (clk),
        .reset       (reset),
        .load_i      (hg_load_s),
        .len_i       (hg_len_s),
        .level_i     (hg_level_s),
        .en_i        (hg_en_s),
        .level_o     (hg_level_o_s),
        .half_done_o (hg_done_s)
    );

    // No new byte once the last one has been taken, and none during the tail.
    assign ready_s        = !hold_full_q && busy_q && (state_q != ST_TAIL) && !last_seen_q;
    assign src.data_ready = ready_s;
    assign xfer_s         = src.data_valid && ready_s;
    // A byte arriving exactly at a load point bypasses the holding register.
    assign avail_s        = hold_full_q || xfer_s;
    assign next_byte_s    = hold_full_q ? hold_q : src.data_in;
    assign next_last_s    = hold_full_q ? hold_last_q : src.data_last;

    // Next-state logic: block sequencing, byte buffering and half-period loads.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        underrun_d   = underrun_q;
        pulse_d      = pulse_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        shift_last_d = shift_last_q;
        hold_d       = hold_q;
        hold_last_d  = hold_last_q;
        hold_full_d  = hold_full_q;
        last_seen_d  = last_seen_q;
        hg_load_s    = 1'b0;
        hg_len_s     = '0;
        hg_level_s   = 1'b0;
        hg_en_s      = 1'b0;
        load_pt_s    = 1'b0;

        if (xfer_s) begin
            hold_d      = src.data_in;
            hold_last_d = src.data_last;
            hold_full_d = 1'b1;
            last_seen_d = last_seen_q | src.data_last;
        end else begin
            hold_full_d = hold_full_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_PILOT;
                    busy_d      = 1'b1;
                    underrun_d  = 1'b0;
                    last_seen_d = 1'b0;
                    pulse_d     = is_header ? L_HDR : L_DAT;
                    hg_load_s   = 1'b1;
                    hg_len_s    = L_PILOT;
                    hg_level_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PILOT: begin
                hg_en_s = 1'b1;
                if (hg_done_s) begin
                    hg_load_s = 1'b1;
                    if (hg_level_o_s) begin
                        hg_len_s   = L_PILOT;
                        hg_level_s = 1'b0;
                    end else if (pulse_q == PULSE_W'(1)) begin
                        state_d    = ST_SYNC1;
                        hg_len_s   = L_SYNC1;
                        hg_level_s = 1'b1;
                    end else begin
                        pulse_d    = pulse_q - PULSE_W'(1);
                        hg_len_s   = L_PILOT;
                        hg_level_s = 1'b1;
                    end
                end else begin
                    hg_load_s = 1'b0;
                end
            end
            ST_SYNC1: begin
                hg_en_s = 1'b1;
                if (hg_done_s) begin
                    state_d    = ST_SYNC2;
                    hg_load_s  = 1'b1;
                    hg_len_s   = L_SYNC2;
                    hg_level_s = 1'b0;
                end else begin
                    hg_load_s = 1'b0;
                end
            end
            ST_SYNC2: begin
                hg_en_s   = 1'b1;
                load_pt_s = hg_done_s;
            end
            ST_DATA: begin
                hg_en_s = 1'b1;
                if (hg_done_s) begin
                    if (hg_level_o_s) begin
                        // Low half of the current bit has the same length.
                        hg_load_s  = 1'b1;
                        hg_len_s   = bit_half_len(shift_q[7], L_ONE, L_ZERO);
                        hg_level_s = 1'b0;
                    end else if (bit_q != 3'd0) begin
                        shift_d    = {shift_q[6:0], 1'b0};
                        bit_d      = bit_q - 3'd1;
                        hg_load_s  = 1'b1;
                        hg_len_s   = bit_half_len(shift_q[6], L_ONE, L_ZERO);
                        hg_level_s = 1'b1;
                    end else if (shift_last_q) begin
                        state_d    = ST_TAIL;
                        hg_load_s  = 1'b1;
                        hg_len_s   = L_TAIL;
                        hg_level_s = 1'b1;
                    end else begin
                        load_pt_s = 1'b1;
                    end
                end else begin
                    hg_load_s = 1'b0;
                end
            end
            ST_STALL: begin
                hg_en_s   = 1'b0;
                load_pt_s = 1'b1;
            end
            ST_TAIL: begin
                hg_en_s = 1'b1;
                if (hg_done_s) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    hold_full_d = 1'b0;
                    last_seen_d = 1'b0;
                    hg_load_s   = 1'b1;
                    hg_len_s    = HALF_W'(1);
                    hg_level_s  = 1'b0;
                end else begin
                    hg_load_s = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                hold_full_d = 1'b0;
                hg_load_s   = 1'b1;
                hg_len_s    = HALF_W'(1);
                hg_level_s  = 1'b0;
            end
        endcase

        // Byte boundary: start the next byte's bit 7 or wait for the source.
        if (load_pt_s) begin
            if (avail_s) begin
                state_d      = ST_DATA;
                shift_d      = next_byte_s;
                shift_last_d = next_last_s;
                bit_d        = 3'd7;
                hold_full_d  = 1'b0;
                hg_load_s    = 1'b1;
                hg_len_s     = bit_half_len(next_byte_s[7], L_ONE, L_ZERO);
                hg_level_s   = 1'b1;
            end else begin
                state_d    = ST_STALL;
                underrun_d = 1'b1;
                if (state_q != ST_STALL) begin
                    hg_load_s  = 1'b1;
                    hg_len_s   = HALF_W'(1);
                    hg_level_s = 1'b0;
                end else begin
                    hg_load_s = 1'b0;
                end
            end
        end else begin
            load_pt_s = 1'b0;
        end

        // Abort outranks everything, including a simultaneous start.
        if (abort) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            underrun_d  = underrun_q;
            hold_full_d = 1'b0;
            last_seen_d = 1'b0;
            hg_load_s   = 1'b1;
            hg_len_s    = HALF_W'(1);
            hg_level_s  = 1'b0;
            hg_en_s     = 1'b0;
        end else begin
            busy_d = busy_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
            pulse_q      <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            shift_last_q <= 1'b0;
            hold_q       <= 8'h00;
            hold_last_q  <= 1'b0;
            hold_full_q  <= 1'b0;
            last_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
            pulse_q      <= pulse_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            shift_last_q <= shift_last_d;
            hold_q       <= hold_d;
            hold_last_q  <= hold_last_d;
            hold_full_q  <= hold_full_d;
            last_seen_q  <= last_seen_d;
        end
    end

    assign ear      = hg_level_o_s;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = underrun_q;

endmodule
